// File: rtl/flow_meter_controller.sv
// Flow meter dispense controller.
// Counts synchronized flow-sensor pulses, converts them to millilitres and
// runs the pump until the requested volume is delivered, a cancel arrives,
// or the sensor stops pulsing for too long (no-flow fault).
module flow_meter_controller #(
  parameter int unsigned PULSES_PER_ML          = 5,
  parameter int unsigned NO_FLOW_TIMEOUT_CYCLES = 50000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [13:0] target_ml,
  input  logic        flow_pulse,
  output logic        pump_on,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [13:0] dispensed_ml
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILLING = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  localparam logic [7:0]  SUB_LAST  = 8'(PULSES_PER_ML - 1);
  localparam logic [31:0] TMO_LIMIT = 32'(NO_FLOW_TIMEOUT_CYCLES);
  localparam logic [13:0] MAX_ML    = 14'd9999;

  state_t      state, state_next;
  logic [1:0]  sync_q;
  logic        pulse_prev;
  logic        pulse_det;
  logic [7:0]  sub_cnt, sub_next;
  logic [31:0] tmo_cnt, tmo_next, tmo_inc;
  logic [13:0] target_q, target_next;
  logic [13:0] disp_next, disp_inc;
  logic        done_next;
  logic        start_ok;

  assign start_ok = start && (target_ml != 14'd0) && (target_ml <= MAX_ML);
  assign disp_inc = dispensed_ml + 14'd1;
  // Saturating increment so a stalled counter can never wrap back to zero.
  assign tmo_inc  = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 32'd1;

  // Synchronize the asynchronous sensor input and register its rising edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b00;
      pulse_prev <= 1'b0;
      pulse_det  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], flow_pulse};
      pulse_prev <= sync_q[1];
      pulse_det  <= sync_q[1] & ~pulse_prev;
    end
  end

  // Next-state and datapath decode; cancel is checked first so it wins over
  // both a completing pulse and a timeout expiry in the same cycle.
  // NOTE: every signal gets its hold value first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next  = state;
    sub_next    = sub_cnt;
    tmo_next    = tmo_cnt;
    target_next = target_q;
    disp_next   = dispensed_ml;
    done_next   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) begin
          target_next = target_ml;
          disp_next   = 14'd0;
          sub_next    = 8'd0;
          tmo_next    = 32'd0;
          state_next  = ST_FILLING;
        end
      end
      ST_FILLING: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else if (pulse_det) begin
          tmo_next = 32'd0;
          if (sub_cnt == SUB_LAST) begin
            sub_next  = 8'd0;
            disp_next = disp_inc;
            if (disp_inc == target_q) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            sub_next = sub_cnt + 8'd1;
          end
        end else begin
          tmo_next = tmo_inc;
          if (tmo_inc >= TMO_LIMIT) begin
            state_next = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs are loaded from the
  // next state so they always match the state register cycle for cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      sub_cnt      <= 8'd0;
      tmo_cnt      <= 32'd0;
      target_q     <= 14'd0;
      dispensed_ml <= 14'd0;
      done         <= 1'b0;
      pump_on      <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_next;
      sub_cnt      <= sub_next;
      tmo_cnt      <= tmo_next;
      target_q     <= target_next;
      dispensed_ml <= disp_next;
      done         <= done_next;
      pump_on      <= (state_next == ST_FILLING);
      busy         <= (state_next == ST_FILLING);
      fault        <= (state_next == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_flow_meter_controller.sv
// Self-checking bench for flow_meter_controller (2 pulses/ml, 20-cycle
// no-flow timeout). Expected values come from a volume-accounting model.
module tb_flow_meter_controller;

  localparam int PPM = 2;
  localparam int TMO = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [13:0] target_ml = 14'd0;
  logic        flow_pulse = 1'b0;
  logic        pump_on, busy, done, fault;
  logic [13:0] dispensed_ml;

  int total = 0;
  int bad = 0;

  // done monitor
  int done_cnt = 0;
  logic pump_at_done = 1'b0;

  // model
  bit m_fill = 0;
  bit m_fault = 0;
  int m_target = 0;
  int m_pulses = 0;
  int m_disp = 0;
  int m_done = 0;

  flow_meter_controller #(
    .PULSES_PER_ML(PPM),
    .NO_FLOW_TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .cancel(cancel),
    .target_ml(target_ml),
    .flow_pulse(flow_pulse),
    .pump_on(pump_on),
    .busy(busy),
    .done(done),
    .fault(fault),
    .dispensed_ml(dispensed_ml)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done) begin
      done_cnt++;
      pump_at_done = pump_on;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"},  32'(busy),         32'(m_fill));
    check({tag, ".pump"},  32'(pump_on),      32'(m_fill));
    check({tag, ".fault"}, 32'(fault),        32'(m_fault));
    check({tag, ".disp"},  32'(dispensed_ml), 32'(m_disp));
    check({tag, ".done"},  32'(done_cnt),     32'(m_done));
  endtask

  // Model: a legal start from idle begins a fresh dispense.
  function automatic void model_start(input int t);
    if (!m_fill && !m_fault && t >= 1 && t <= 9999) begin
      m_fill = 1; m_target = t; m_pulses = 0; m_disp = 0;
    end
  endfunction

  // Model: volume is whole pulses divided by pulses-per-ml, capped at target.
  function automatic void model_pulse();
    if (m_fill) begin
      m_pulses++;
      m_disp = m_pulses / PPM;
      if (m_disp >= m_target) begin
        m_disp = m_target; m_fill = 0; m_done++;
      end
    end
  endfunction

  task automatic do_start(input int t);
    start = 1'b1; target_ml = 14'(t);
    tick(1);
    start = 1'b0;
    model_start(t);
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick(1);
    cancel = 1'b0;
    m_fill = 0; m_fault = 0;
  endtask

  // One sensor pulse every 5 cycles; detection lands 3 edges after the rise.
  task automatic send_pulse();
    flow_pulse = 1'b1;
    tick(2);
    flow_pulse = 1'b0;
    tick(3);
    model_pulse();
  endtask

  initial begin
    int t, n;
    // Reset state, held for several clocks.
    tick(3);
    check_all("reset");
    reset = 1'b1;
    tick(1);
    check_all("post_reset");

    // Illegal starts are ignored.
    do_start(0);     tick(1); check_all("illegal_zero");
    do_start(10000); tick(1); check_all("illegal_10000");
    do_start(16383); tick(1); check_all("illegal_max");

    // Normal dispense of 3 ml: volume steps every second pulse.
    do_start(3);
    check_all("fill3_start");
    for (int i = 0; i < 6; i++) begin
      send_pulse();
      check_all($sformatf("fill3_p%0d", i + 1));
    end
    check("fill3_pump_at_done", 32'(pump_at_done), 32'd0);

    // Pulses while idle change nothing.
    send_pulse(); send_pulse();
    check_all("idle_pulses");

    // Cancel mid-dispense keeps partial volume, no done.
    do_start(5);
    for (int i = 0; i < 4; i++) send_pulse();
    check_all("cancel_before");
    do_cancel();
    tick(1);
    check_all("cancel_after");

    // No-flow timeout.
    do_start(5);
    send_pulse();
    tick(10);
    check_all("tmo_not_yet");
    tick(15);
    m_fill = 0; m_fault = 1;
    check_all("tmo_fault");
    do_start(3); tick(1);
    check_all("tmo_start_ignored");
    do_cancel(); tick(1);
    check_all("tmo_cleared");

    // Cancel on the exact cycle the timeout would expire: no fault.
    do_start(4);
    tick(TMO - 1);
    check_all("tmo_edge_before");
    do_cancel(); tick(1);
    check_all("tmo_edge_cancel");

    // Cancel coincident with the completing pulse detection: no done.
    do_start(2);
    for (int i = 0; i < 3; i++) send_pulse();
    check_all("sim_before");
    flow_pulse = 1'b1; tick(2);
    flow_pulse = 1'b0; tick(1);
    cancel = 1'b1;     tick(1);
    cancel = 1'b0;     tick(2);
    m_fill = 0;
    check_all("sim_cancel");
    check("sim_disp_target_m1", 32'(dispensed_ml), 32'd1);

    // Start during fill is ignored; original target is kept.
    do_start(2);
    send_pulse();
    do_start(4);
    for (int i = 0; i < 3; i++) send_pulse();
    check_all("midfill_start");

    // Randomized dispenses against the model.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) t = $urandom_range(10000, 16383);
      else                           t = $urandom_range(1, 4);
      n = $urandom_range(0, 2 * 4 + 2);
      do_start(t);
      for (int i = 0; i < n; i++) send_pulse();
      if (m_fill) do_cancel();
      tick(1);
      check_all($sformatf("rand%0d_t%0d_n%0d", k, t, n));
    end

    // Asynchronous reset mid-fill.
    do_start(4);
    for (int i = 0; i < 4; i++) send_pulse();
    check_all("rst_before");
    #2 reset = 1'b0;
    #1;
    m_fill = 0; m_fault = 0; m_disp = 0;
    check_all("rst_async");
    tick(1);
    reset = 1'b1;
    tick(1);
    do_start(1);
    send_pulse(); send_pulse();
    check_all("rst_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flow_meter_controller.md
FLOW_METER_CONTROLLER -- requirements
Module: flow_meter_controller

Interface
REQ-001 SHALL have parameter PULSES_PER_ML, default 5, meaning flow-sensor pulses per millilitre (legal range 1..255).
REQ-002 SHALL have parameter NO_FLOW_TIMEOUT_CYCLES, default 50000000, meaning clock cycles without a sensor pulse before a fault (1 s at 50 MHz).
REQ-003 SHALL have port: clock  input  1  system clock, rising edge active.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port: start  input  1  single-cycle request to begin a dispense of target_ml.
REQ-006 SHALL have port: cancel  input  1  single-cycle abort request.
REQ-007 SHALL have port: target_ml  input  14  requested volume in ml, sampled only on an accepted start.
REQ-008 SHALL have port: flow_pulse  input  1  raw flow-sensor pulse, asynchronous to clock.
REQ-009 SHALL have port: pump_on  output  1  pump relay drive, registered.
REQ-010 SHALL have port: busy  output  1  high while in FILLING.
REQ-011 SHALL have port: done  output  1  one-cycle pulse when the target volume is reached.
REQ-012 SHALL have port: fault  output  1  no-flow fault flag, held until cleared.
REQ-013 SHALL have port: dispensed_ml  output  14  millilitres delivered in the current or most recent dispense.

Function
REQ-014 SHALL pass flow_pulse through a 2-flop synchronizer, then a registered rising-edge detector; one detected edge equals one sensor pulse.
REQ-015 SHALL implement exactly three states: IDLE, FILLING and FAULT; pump_on and busy SHALL both equal (state == FILLING), registered.
REQ-016 IDLE: a start with target_ml in 1..9999 SHALL latch the target, clear dispensed_ml, the pulse sub-counter and the timeout counter, and enter FILLING at the same clock edge.
REQ-017 IDLE: a start with target_ml = 0 or > 9999 SHALL be ignored, with no state change and no output change.
REQ-018 IDLE: detected pulses SHALL be ignored; dispensed_ml SHALL hold its last value.
REQ-019 FILLING: each detected pulse SHALL increment the sub-counter; on the pulse that would reach PULSES_PER_ML, the sub-counter SHALL wrap to 0 and dispensed_ml SHALL increment by 1.
REQ-020 FILLING: when an increment makes dispensed_ml equal the latched target, the block SHALL go to IDLE at that edge and pulse done for exactly one cycle; pump_on SHALL be low from the next cycle.
REQ-021 FILLING: cancel SHALL go to IDLE with no done pulse; dispensed_ml SHALL retain the partial volume.
REQ-022 FILLING: the timeout counter SHALL clear on every detected pulse and increment otherwise; on reaching NO_FLOW_TIMEOUT_CYCLES it SHALL go to FAULT and set fault.
REQ-023 FILLING: start SHALL be ignored, and the latched target SHALL NOT change mid-dispense.
REQ-024 FAULT: pump_on = 0 and fault = 1; start and pulses SHALL be ignored; cancel SHALL clear fault and go to IDLE; dispensed_ml SHALL hold.
REQ-025 Simultaneous events: cancel SHALL have priority over a completing pulse (no done) and over a timeout expiry (no fault).
REQ-026 Arithmetic: the sub-counter SHALL be 8 bits and the timeout counter SHALL be 32 bits and saturating; dispensed_ml SHALL never exceed the latched target.

Reset
REQ-027 While reset = 0, the block SHALL be in IDLE with pump_on = 0, busy = 0, done = 0, fault = 0, dispensed_ml = 0, all counters = 0, and synchronizer flops = 0, all asynchronously.
REQ-028 Reset asserted mid-FILLING or in FAULT SHALL drop pump_on immediately, without waiting for a clock edge.
REQ-029 After reset is released, the first accepted start SHALL be the first clock edge with start = 1 and a legal target.

Verification (PULSES_PER_ML=2, NO_FLOW_TIMEOUT_CYCLES=20)
REQ-030 Normal dispense: start with target_ml=3, then 6 pulses spaced 5 cycles apart -> dispensed_ml steps 1,2,3; done pulses once on the 6th pulse; pump_on falls on the next cycle.
REQ-031 Illegal start: start with target_ml=0, then start with target_ml=10000 -> stays IDLE, pump_on = 0 throughout.
REQ-032 Cancel: start with target_ml=5, 4 pulses, then cancel -> IDLE, dispensed_ml = 2, no done pulse.
REQ-033 Timeout: start with target_ml=5, 1 pulse, then 20 pulse-free cycles -> fault = 1, pump_on = 0; a following start is ignored; cancel -> fault = 0 and IDLE.
REQ-034 Simultaneous events: cancel in the same cycle as the completing pulse detection -> no done pulse, dispensed_ml = target - 1.
REQ-035 Reset mid-fill: reset = 0 during FILLING with dispensed_ml = 2 -> pump_on = 0 and dispensed_ml = 0 asynchronously.
